// File: rtl/signed_div.sv
// signed_div: sequential W-bit signed integer divider (restoring algorithm).
// Divides signed N by signed D on operand magnitudes, one quotient bit per
// Shift/Trial pair, then applies sign correction in Fix.
// Quotient truncates toward zero; remainder takes the sign of N (Q*D+R = N).
//
// Ports:
//   i_Clock    rising-edge clock
//   i_Reset    synchronous, active-high; returns to Init and clears registers
//   i_Start    begin a division (sampled only in Init)
//   i_N, i_D   signed dividend / divisor (W bits), sampled in Load
//   o_Q, o_R   signed quotient / remainder, valid while o_Done is high
//   o_Done     one-cycle completion pulse
//   o_Busy     high in every state except Init
//   o_DivZero  divisor was zero (valid with o_Done)
//   o_Ovf      N = -2^(W-1) and D = -1 (valid with o_Done)
//
// Optional build macro SIGNED_DIV_HOLD_EN: when defined, Q/R/DivZero/Ovf are
// held after Done through Init until the next Load, instead of reading 0.
module signed_div #(
    parameter int unsigned W = 16
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic         i_Start,
    input  logic [W-1:0] i_N,
    input  logic [W-1:0] i_D,
    output logic [W-1:0] o_Q,
    output logic [W-1:0] o_R,
    output logic         o_Done,
    output logic         o_Busy,
    output logic         o_DivZero,
    output logic         o_Ovf
);

    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRIAL = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_ctr;
    logic [W:0]     r_a;          // partial remainder, one bit wider than Dmag
    logic [W-1:0]   r_qreg;       // dividend magnitude shifting out, quotient in
    logic [W-1:0]   r_dmag;
    logic           r_sn;
    logic           r_sd;
    logic           r_ovf_cand;   // captured N==-2^(W-1) && D==-1
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_done;
    logic           r_busy;
    logic           r_divzero;
    logic           r_ovf;

    logic [W-1:0]   w_nmag;
    logic [W-1:0]   w_dmag;
    logic           w_ovf_cand;
    logic [2*W:0]   w_shift;
    logic [W+1:0]   w_trial;
    logic [W-1:0]   w_qneg;
    logic [W-1:0]   w_rneg;

    // Magnitudes: negating -2^(W-1) yields 2^(W-1), which is correct unsigned.
    assign w_nmag     = i_N[W-1] ? W'(-i_N) : i_N;
    assign w_dmag     = i_D[W-1] ? W'(-i_D) : i_D;
    assign w_ovf_cand = (i_N == {1'b1, {(W-1){1'b0}}}) && (i_D == {W{1'b1}});

    assign w_shift = {r_a, r_qreg} << 1;
    // Extra top bit makes the trial subtraction's sign unambiguous.
    assign w_trial = {1'b0, r_a} - {2'b00, r_dmag};
    assign w_qneg  = W'(-r_qreg);
    assign w_rneg  = W'(-r_a[W-1:0]);

    // Controller and datapath
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= S_INIT;
            r_ctr      <= CW'(W);
            r_a        <= '0;
            r_qreg     <= '0;
            r_dmag     <= '0;
            r_sn       <= 1'b0;
            r_sd       <= 1'b0;
            r_ovf_cand <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_divzero  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (i_Start) begin
                        r_state   <= S_LOAD;
                        r_busy    <= 1'b1;
                        // Held results are dropped as the next division loads.
                        r_q       <= '0;
                        r_r       <= '0;
                        r_divzero <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end

                S_LOAD: begin
                    r_sn       <= i_N[W-1];
                    r_sd       <= i_D[W-1];
                    r_dmag     <= w_dmag;
                    r_a        <= '0;
                    r_qreg     <= w_nmag;
                    r_ctr      <= CW'(W);
                    r_ovf_cand <= w_ovf_cand;
                    if (i_D == '0) begin
                        // Divide-by-zero short-circuits straight to Done.
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_q       <= '1;
                        r_r       <= i_N;
                        r_divzero <= 1'b1;
                        r_ovf     <= 1'b0;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_a     <= w_shift[2*W:W];
                    r_qreg  <= w_shift[W-1:0];
                    r_ctr   <= r_ctr - CW'(1);
                    r_state <= S_TRIAL;
                end

                S_TRIAL: begin
                    if (!w_trial[W+1]) begin
                        r_a       <= w_trial[W:0];
                        r_qreg[0] <= 1'b1;
                    end
                    r_state <= (r_ctr == '0) ? S_FIX : S_SHIFT;
                end

                S_FIX: begin
                    // Overflow case falls out naturally: Q wraps to 0x8..0, R=0.
                    r_q       <= (r_sn ^ r_sd) ? w_qneg : r_qreg;
                    r_r       <= r_sn ? w_rneg : r_a[W-1:0];
                    r_ovf     <= r_ovf_cand;
                    r_divzero <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_INIT;
`ifdef SIGNED_DIV_HOLD_EN
`else
                    r_q       <= '0;
                    r_r       <= '0;
                    r_divzero <= 1'b0;
                    r_ovf     <= 1'b0;
`endif
                end

                default: begin
                    r_state <= S_INIT;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Q       = r_q;
    assign o_R       = r_r;
    assign o_Done    = r_done;
    assign o_Busy    = r_busy;
    assign o_DivZero = r_divzero;
    assign o_Ovf     = r_ovf;

endmodule

// File: doc/signed_div.md
# signed_div

- Sequential W-bit signed integer divider: dividend N / divisor D → quotient Q and remainder R.
- Restoring shift/subtract algorithm on operand magnitudes, one quotient bit per two-cycle iteration, sign correction at the end.
- Inverse companion of the team's sequential Booth multiplier; shares its Start-driven, single-cycle-Done controller style and its arithmetic datapath conventions.

## Interface
- W, 16, operand/result bit width (W ≥ 4); iteration counter width $clog2(W)+1.
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high; forces Init and clears all registers.
- Start  input  1  begin a division; sampled only in Init.
- N  input  W  signed dividend, sampled in Load.
- D  input  W  signed divisor, sampled in Load.
- Q  output  W  signed quotient, truncated toward zero.
- R  output  W  signed remainder; sign of N; Q*D+R = N.
- Done  output  1  one-cycle pulse; Q/R/flags valid this cycle.
- Busy  output  1  high in every state except Init.
- DivZero  output  1  D was 0; valid with Done.
- Ovf  output  1  N = -2^(W-1) and D = -1; valid with Done.

## Operation
- States: Init, Load, Shift, Trial, Fix, Done.
- Init:
  - Start=1 → Load; else stay.
  - Start in any other state is ignored.
- Load:
  - Capture sN=N[W-1], sD=D[W-1], Nmag=|N|, Dmag=|D| (W-bit unsigned; |-2^(W-1)| = 2^(W-1)).
  - A (W+1 bits) ← 0; Qreg ← Nmag; CTR ← W.
  - D==0 → Done with DivZero; else → Shift.
- Shift: {A,Qreg} ← {A,Qreg} << 1; CTR ← CTR-1; → Trial.
- Trial:
  - T = A - {1'b0,Dmag}.
  - T ≥ 0: A ← T, Qreg[0] ← 1.
  - Else: A unchanged, Qreg[0] stays 0.
  - CTR==0 → Fix; else → Shift.
- Fix:
  - Qres ← (sN^sD) ? -Qreg : Qreg.
  - Rres ← sN ? -A[W-1:0] : A[W-1:0].
  - Ovf ← (N==-2^(W-1) && D==-1) using the captured operands.
  - Q wraps to -2^(W-1) and R = 0 in the overflow case.
- Done:
  - Divide-by-zero: Q = all ones, R = N, DivZero=1, Ovf=0.
  - → Init unconditionally.
- Outputs:
  - Q, R, DivZero and Ovf are 0 in every cycle except Done (see Configuration).
  - Done = (State==Done).
- Reset mid-operation:
  - Next state Init; Busy, Done, Q, R and flags read 0 from the following cycle.
  - No partial result is ever presented.
- Reset values: Q=0, R=0, Done=0, Busy=0, DivZero=0, Ovf=0, CTR=W, A=0, Qreg=0.

## Timing
- Start high at edge t0 (state Init) → Load after t0.
- Iteration i (1..W): Shift after edge t0+2i, Trial after edge t0+2i+1.
- Fix after edge t0+2W+2; Done after edge t0+2W+3; Init after t0+2W+4.
- Latency Start → Done = 2W+3 cycles (35 for W=16); back-to-back throughput one division per 2W+4 cycles.
- Divide-by-zero: Done after edge t0+2.
- Start held high through Done → new division, Load after t0+2W+5.

## Configuration
- SIGNED_DIV_HOLD_EN defined:
  - Q, R, DivZero and Ovf are registered at Done and held through Init until the next Load.
  - Cleared to 0 at Load and on Reset.
  - Done still pulses one cycle.
- Undefined: outputs are 0 outside the Done cycle, matching the multiplier's P behaviour.

## Test plan
- W=16, N=100, D=7, Start pulse at t0 → Done only at t0+35; Q=14, R=2, DivZero=0, Ovf=0; Busy high t0+1..t0+35.
- Sign matrix (W=16):
  - N=-100, D=7 → Q=-14, R=-2.
  - N=100, D=-7 → Q=-14, R=2.
  - N=-100, D=-7 → Q=14, R=-2.
  - N=3, D=7 → Q=0, R=3.
- N=-32768, D=-1 → Q=-32768 (0x8000), R=0, Ovf=1; N=-32768, D=1 → Q=-32768, R=0, Ovf=0.
- N=5, D=0 → Done at t0+2, Q=0xFFFF, R=5, DivZero=1; next division with D=3 → Q=1, R=2, DivZero=0.
- Reset asserted one cycle at t0+10 of a 100/7 run → Busy=0 and outputs 0 at t0+11; Start at t0+12 with 1000/33 → Q=30, R=10 at t0+47.
- Start re-pulsed at t0+5 and t0+20 during a 100/7 run → ignored; single Done at t0+35. With SIGNED_DIV_HOLD_EN: Q=14, R=2 remain on outputs until the next Load.
